// File: rtl/ifetch_ctrl.sv
// -----------------------------------------------------------------------------
// ifetch_ctrl
//   Instruction-fetch controller sitting directly after pc_reg. It issues one
//   request/grant/response transaction per instruction to instruction memory
//   and holds the fetched word in a valid/ready register toward decode. It also
//   owns the PC write-enable, so the PC only moves when decode takes an
//   instruction or when a redirect (flush) is presented.
//
// Ports
//   i_clk, i_rst      clock (rising edge), asynchronous active-high reset
//   i_pc              current PC from pc_reg
//   i_flush           redirect; the next-PC mux shows the target this cycle
//   o_pc_wren         write-enable to pc_reg
//   o_imem_req        memory request (combinational in REQ)
//   o_imem_addr       request address (equals i_pc while requesting)
//   i_imem_gnt        request accepted this cycle
//   i_imem_rvalid     read data valid, one response per grant
//   i_imem_rdata      read data
//   o_instr_valid     instruction available to decode
//   o_instr           fetched instruction
//   o_instr_pc        PC of o_instr
//   i_instr_ready     decode accepts o_instr
//   o_misalign        sticky: PC was not word aligned at request time
//   o_timeout         sticky: memory did not answer within TIMEOUT_CYC cycles
// -----------------------------------------------------------------------------
module ifetch_ctrl #(
   parameter int unsigned TIMEOUT_CYC = 255,
   parameter int unsigned CNT_W       = 8
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [31:0] i_pc,
   input  logic        i_flush,
   output logic        o_pc_wren,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_gnt,
   input  logic        i_imem_rvalid,
   input  logic [31:0] i_imem_rdata,
   output logic        o_instr_valid,
   output logic [31:0] o_instr,
   output logic [31:0] o_instr_pc,
   input  logic        i_instr_ready,
   output logic        o_misalign,
   output logic        o_timeout
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_HOLD,
      S_DRAIN,
      S_ERR
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_inc;
   logic             cnt_expired;
   logic             pc_aligned;

   assign pc_aligned = (i_pc[1:0] == 2'b00);

   // Saturating increment: the counter sticks at all-ones instead of wrapping.
   assign cnt_inc     = (cnt == '1) ? cnt : cnt + 1'b1;
   // Evaluated on the incremented value so the wait ends after exactly
   // TIMEOUT_CYC cycles in WAIT/DRAIN.
   assign cnt_expired = (cnt_inc >= CNT_W'(TIMEOUT_CYC));

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking (<=) so every flop samples the
   // pre-edge values of the others, independent of process ordering.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= S_IDLE;
      else       state <= state_next;
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   // NOTE: state_next gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_next = state;
      unique case (state)
         S_IDLE:  state_next = S_REQ;
         S_REQ: begin
            // A flush re-requests with the new target; a gnt in the same
            // cycle is deliberately ignored.
            if (i_flush)          state_next = S_REQ;
            else if (!pc_aligned) state_next = S_ERR;
            else if (i_imem_gnt)  state_next = S_WAIT;
         end
         S_WAIT: begin
            // Flush without data means a response is still in flight and must
            // be swallowed in DRAIN; flush with data drops it right here.
            if (i_flush)            state_next = i_imem_rvalid ? S_REQ : S_DRAIN;
            else if (i_imem_rvalid) state_next = S_HOLD;
            else if (cnt_expired)   state_next = S_ERR;
         end
         S_HOLD: begin
            if (i_flush || i_instr_ready) state_next = S_REQ;
         end
         S_DRAIN: begin
            // A further flush only moves the PC; the stale response is still
            // owed, so DRAIN keeps waiting for it.
            if (i_imem_rvalid || cnt_expired) state_next = S_REQ;
         end
         S_ERR: begin
            if (i_flush) state_next = S_REQ;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Outputs decoded from state
   // ---------------------------------------------------------------------------
   always_comb begin
      o_imem_req    = (state == S_REQ) && pc_aligned;
      o_imem_addr   = o_imem_req ? i_pc : 32'h0;
      o_instr_valid = (state == S_HOLD);
      // Flush alone covers the flush+ready case, giving a single PC write.
      o_pc_wren     = !i_rst && (i_flush || ((state == S_HOLD) && i_instr_ready));
   end

   // ---------------------------------------------------------------------------
   // Datapath: instruction register, timeout counter, sticky error flags
   // ---------------------------------------------------------------------------
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt        <= '0;
         o_instr    <= 32'h0;
         o_instr_pc <= 32'h0;
         o_misalign <= 1'b0;
         o_timeout  <= 1'b0;
      end else begin
         unique case (state)
            S_REQ: begin
               if (!i_flush && pc_aligned && i_imem_gnt) begin
                  o_instr_pc <= i_pc;
                  cnt        <= '0;
               end
               if (!i_flush && !pc_aligned) o_misalign <= 1'b1;
            end
            S_WAIT: begin
               if (i_flush && !i_imem_rvalid) begin
                  // Fresh window for the stale response in DRAIN.
                  cnt <= '0;
               end else begin
                  cnt <= cnt_inc;
               end
               if (!i_flush && i_imem_rvalid) o_instr <= i_imem_rdata;
               if (!i_flush && !i_imem_rvalid && cnt_expired) o_timeout <= 1'b1;
            end
            S_DRAIN: cnt <= cnt_inc;
            S_ERR: begin
               if (i_flush) begin
                  o_misalign <= 1'b0;
                  o_timeout  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ifetch_ctrl
//   Self-checking bench for ifetch_ctrl. The bench plays pc_reg (advancing the
//   PC on o_pc_wren) and instruction memory (gnt/rvalid driven per scenario).
//   Every instruction that should reach decode is pushed to a scoreboard when
//   its response is driven and popped when decode takes it.
// -----------------------------------------------------------------------------
module tb_ifetch_ctrl;

   localparam int unsigned TIMEOUT_CYC = 4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc;
   logic        flush;
   logic [31:0] target;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;
   logic        ready;

   logic        o_pc_wren;
   logic        o_imem_req;
   logic [31:0] o_imem_addr;
   logic        o_instr_valid;
   logic [31:0] o_instr;
   logic [31:0] o_instr_pc;
   logic        o_misalign;
   logic        o_timeout;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   ifetch_ctrl #(.TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(8)) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_pc          (pc),
      .i_flush       (flush),
      .o_pc_wren     (o_pc_wren),
      .o_imem_req    (o_imem_req),
      .o_imem_addr   (o_imem_addr),
      .i_imem_gnt    (gnt),
      .i_imem_rvalid (rvalid),
      .i_imem_rdata  (rdata),
      .o_instr_valid (o_instr_valid),
      .o_instr       (o_instr),
      .o_instr_pc    (o_instr_pc),
      .i_instr_ready (ready),
      .o_misalign    (o_misalign),
      .o_timeout     (o_timeout)
   );

   // One clock cycle, entered and left at the falling edge. Monitors the
   // decode handshake against the scoreboard and models pc_reg.
   task automatic step();
      exp_t        e;
      logic        wren_s;
      logic        flush_s;
      logic [31:0] tgt_s;
      #1;
      wren_s  = o_pc_wren;
      flush_s = flush;
      tgt_s   = target;
      if (!rst && o_instr_valid && ready && !flush) begin
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: got instr %08h pc %08h, expected no instruction", o_instr, o_instr_pc);
         end else begin
            e = sb.pop_front();
            if (o_instr !== e.instr || o_instr_pc !== e.pc) begin
               n_fail++;
               $display("FAIL sb_instr: got instr %08h pc %08h, expected instr %08h pc %08h", o_instr, o_instr_pc, e.instr, e.pc);
            end
         end
      end
      @(posedge clk);
      #1;
      if (wren_s) pc = flush_s ? tgt_s : pc + 32'd4;
      @(negedge clk);
   endtask

   task automatic push_exp(input logic [31:0] p, input logic [31:0] d);
      exp_t e;
      e.pc    = p;
      e.instr = d;
      sb.push_back(e);
   endtask

   task automatic test_reset();
      // Fetch one word into HOLD, then hit it with an asynchronous reset.
      rst = 1'b0;
      step();
      gnt = 1'b1;
      step();
      gnt = 1'b0; rvalid = 1'b1; rdata = 32'h0050_0093;
      step();
      rvalid = 1'b0; ready = 1'b0;
      #1;
      n_checks++; if (o_instr_valid !== 1'b1 || o_instr !== 32'h0050_0093) begin n_fail++; $display("FAIL reset_prehold: got valid %b instr %08h, expected 1 00500093", o_instr_valid, o_instr); end
      rst = 1'b1;
      #1;
      n_checks++; if (o_instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", o_instr_valid); end
      n_checks++; if (o_instr !== 32'h0 || o_instr_pc !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %08h/%08h expected 0/0", o_instr, o_instr_pc); end
      n_checks++; if (o_imem_req !== 1'b0 || o_imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_req: got %b/%08h expected 0/0", o_imem_req, o_imem_addr); end
      n_checks++; if (o_pc_wren !== 1'b0 || o_misalign !== 1'b0 || o_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_misc: got wren %b mis %b to %b expected 0 0 0", o_pc_wren, o_misalign, o_timeout); end
      step();
      step();
      pc  = 32'h0;
      rst = 1'b0;
      #1;
      n_checks++; if (o_imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_idle: got req %b expected 0", o_imem_req); end
      step();
      #1;
      n_checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_firstreq: got %b/%08h expected 1/00000000", o_imem_req, o_imem_addr); end
   endtask

   task automatic test_normal_fetch();
      gnt = 1'b1;
      step();
      gnt = 1'b0; rvalid = 1'b1; rdata = 32'h0050_0093;
      push_exp(32'h0, rdata);
      step();
      rvalid = 1'b0; ready = 1'b1;
      #1;
      n_checks++; if (o_instr_valid !== 1'b1 || o_instr_pc !== 32'h0) begin n_fail++; $display("FAIL fetch_hold: got valid %b pc %08h expected 1 00000000", o_instr_valid, o_instr_pc); end
      n_checks++; if (o_pc_wren !== 1'b1) begin n_fail++; $display("FAIL fetch_wren: got %b expected 1", o_pc_wren); end
      step();
      ready = 1'b0;
      #1;
      n_checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h4) begin n_fail++; $display("FAIL fetch_next: got %b/%08h expected 1/00000004", o_imem_req, o_imem_addr); end
      n_checks++; if (o_instr_valid !== 1'b0) begin n_fail++; $display("FAIL fetch_validclr: got %b expected 0", o_instr_valid); end
   endtask

   task automatic test_backpressure();
      gnt = 1'b1;
      step();
      gnt = 1'b0; rvalid = 1'b1; rdata = 32'h00A0_0113;
      push_exp(32'h4, rdata);
      step();
      rvalid = 1'b0; ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_checks++; if (o_instr_valid !== 1'b1 || o_instr !== 32'h00A0_0113 || o_pc_wren !== 1'b0) begin n_fail++; $display("FAIL bp_stall%0d: got valid %b instr %08h wren %b expected 1 00a00113 0", i, o_instr_valid, o_instr, o_pc_wren); end
         step();
      end
      ready = 1'b1;
      #1;
      n_checks++; if (o_pc_wren !== 1'b1) begin n_fail++; $display("FAIL bp_wren: got %b expected 1", o_pc_wren); end
      step();
      ready = 1'b0;
      #1;
      n_checks++; if (o_pc_wren !== 1'b0 || o_imem_addr !== 32'h8) begin n_fail++; $display("FAIL bp_after: got wren %b addr %08h expected 0 00000008", o_pc_wren, o_imem_addr); end
   endtask

   task automatic test_flush_wait();
      gnt = 1'b1;
      step();
      gnt = 1'b0; flush = 1'b1; target = 32'h40;
      #1;
      n_checks++; if (o_pc_wren !== 1'b1) begin n_fail++; $display("FAIL fw_wren: got %b expected 1", o_pc_wren); end
      step();
      flush = 1'b0;
      #1;
      n_checks++; if (o_pc_wren !== 1'b0 || o_imem_req !== 1'b0 || o_instr_valid !== 1'b0) begin n_fail++; $display("FAIL fw_drain: got wren %b req %b valid %b expected 0 0 0", o_pc_wren, o_imem_req, o_instr_valid); end
      step();
      rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
      #1;
      n_checks++; if (o_pc_wren !== 1'b0 || o_instr_valid !== 1'b0) begin n_fail++; $display("FAIL fw_stale: got wren %b valid %b expected 0 0", o_pc_wren, o_instr_valid); end
      step();
      rvalid = 1'b0;
      #1;
      n_checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h40 || o_instr_valid !== 1'b0) begin n_fail++; $display("FAIL fw_target: got req %b addr %08h valid %b expected 1 00000040 0", o_imem_req, o_imem_addr, o_instr_valid); end
      // Real fetch at the target; the scoreboard rejects DEADBEEF here.
      gnt = 1'b1;
      step();
      gnt = 1'b0; rvalid = 1'b1; rdata = 32'h0000_0013;
      push_exp(32'h40, rdata);
      step();
      rvalid = 1'b0; ready = 1'b1;
      step();
      ready = 1'b0;
   endtask

   task automatic test_flush_hold();
      gnt = 1'b1;
      step();
      gnt = 1'b0; rvalid = 1'b1; rdata = 32'h1111_1111;
      step();
      rvalid = 1'b0; ready = 1'b1; flush = 1'b1; target = 32'h80;
      #1;
      n_checks++; if (o_pc_wren !== 1'b1 || o_instr_valid !== 1'b1) begin n_fail++; $display("FAIL fh_both: got wren %b valid %b expected 1 1", o_pc_wren, o_instr_valid); end
      step();
      ready = 1'b0; flush = 1'b0;
      #1;
      n_checks++; if (o_pc_wren !== 1'b0 || o_instr_valid !== 1'b0) begin n_fail++; $display("FAIL fh_after: got wren %b valid %b expected 0 0", o_pc_wren, o_instr_valid); end
      n_checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h80 || pc !== 32'h80) begin n_fail++; $display("FAIL fh_target: got req %b addr %08h pc %08h expected 1 00000080 00000080", o_imem_req, o_imem_addr, pc); end
   endtask

   task automatic test_errors();
      pc = 32'h6;
      #1;
      n_checks++; if (o_imem_req !== 1'b0) begin n_fail++; $display("FAIL err_noreq: got %b expected 0", o_imem_req); end
      step();
      for (int i = 0; i < 3; i++) begin
         #1;
         n_checks++; if (o_misalign !== 1'b1 || o_imem_req !== 1'b0 || o_instr_valid !== 1'b0) begin n_fail++; $display("FAIL err_mis%0d: got mis %b req %b valid %b expected 1 0 0", i, o_misalign, o_imem_req, o_instr_valid); end
         step();
      end
      flush = 1'b1; target = 32'h100;
      step();
      flush = 1'b0;
      #1;
      n_checks++; if (o_misalign !== 1'b0 || o_imem_req !== 1'b1 || o_imem_addr !== 32'h100) begin n_fail++; $display("FAIL err_misclr: got mis %b req %b addr %08h expected 0 1 00000100", o_misalign, o_imem_req, o_imem_addr); end
      gnt = 1'b1;
      step();
      gnt = 1'b0;
      for (int i = 1; i <= int'(TIMEOUT_CYC); i++) begin
         step();
         #1;
         n_checks++; if (o_timeout !== (i == int'(TIMEOUT_CYC))) begin n_fail++; $display("FAIL err_to%0d: got %b expected %b", i, o_timeout, (i == int'(TIMEOUT_CYC))); end
      end
      n_checks++; if (o_imem_req !== 1'b0) begin n_fail++; $display("FAIL err_toreq: got %b expected 0", o_imem_req); end
      flush = 1'b1; target = 32'h200;
      step();
      flush = 1'b0;
      #1;
      n_checks++; if (o_timeout !== 1'b0 || o_imem_req !== 1'b1 || o_imem_addr !== 32'h200) begin n_fail++; $display("FAIL err_toclr: got to %b req %b addr %08h expected 0 1 00000200", o_timeout, o_imem_req, o_imem_addr); end
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 3; k++) begin
         int w;
         gnt = 1'b1;
         #1;
         n_checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h200 + 32'(4 * k)) begin n_fail++; $display("FAIL b2b_req%0d: got %b/%08h expected 1/%08h", k, o_imem_req, o_imem_addr, 32'h200 + 32'(4 * k)); end
         step();
         gnt = 1'b0; rvalid = 1'b1; rdata = 32'h0010_0093 + 32'(k);
         push_exp(32'h200 + 32'(4 * k), rdata);
         step();
         rvalid = 1'b0; ready = 1'b1;
         w = 0;
         while (!o_instr_valid && w < 8) begin
            step();
            w++;
         end
         n_checks++; if (o_instr_valid !== 1'b1 || w != 0) begin n_fail++; $display("FAIL b2b_lat%0d: got valid %b after %0d extra cycles, expected 1 after 0", k, o_instr_valid, w); end
         step();
         ready = 1'b0;
      end
      #1;
      n_checks++; if (pc !== 32'h20C || o_imem_addr !== 32'h20C) begin n_fail++; $display("FAIL b2b_pc: got pc %08h addr %08h expected 0000020c", pc, o_imem_addr); end
   endtask

   initial begin
      rst = 1'b1; pc = 32'h0; flush = 1'b0; target = 32'h0;
      gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0; ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      test_reset();
      test_normal_fetch();
      test_backpressure();
      test_flush_wait();
      test_flush_hold();
      test_errors();
      test_back_to_back();
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL sb_leftover: got %0d undelivered instructions, expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
